read_bus_arbiter: RTL and testbench
===================================

Name: read_bus_arbiter

Overview:
Arbitrates the core's instruction-read (ir_*) and data-read (dr_*) channels onto a single read port (r_*) of the simulation memory, and routes each response back to the requester that issued it. It sits directly upstream of the memory model's read port. It replaces ad-hoc OR-ing of the two channels with a registered, single-outstanding-transaction arbiter. Only one read is in flight at a time, so ownership of every returned beat is unambiguous.

Parameters:
- DATA_WIDTH, `BUS_WIDTH (32): width of the address and data buses on all channels.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low.
- ir_addr_valid  in  1  instruction-read request valid.
- ir_addr_ready  out  1  instruction-read request accepted.
- ir_addr  in  DATA_WIDTH  instruction-read byte address.
- ir_data_valid  out  1  instruction-read data valid.
- ir_data_ready  in  1  core ready for instruction data.
- ir_data  out  DATA_WIDTH  instruction-read data.
- dr_addr_valid, dr_addr_ready, dr_addr, dr_data_valid, dr_data_ready, dr_data: same directions, widths and meanings as the ir_* ports, for the data-read channel.
- r_addr_valid  out  1  request valid to memory.
- r_addr_ready  in  1  memory accepts the request.
- r_addr  out  DATA_WIDTH  address to memory.
- r_data_valid  in  1  memory data valid.
- r_data_ready  out  1  arbiter ready for memory data.
- r_data  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM with three states: IDLE, REQ and RESP.
- Registers: state, owner (IR/DR), addr_q[DATA_WIDTH-1:0].
- Reset (rst==0 at posedge): state=IDLE, owner=IR, addr_q=0, and, under READ_ARB_ROUND_ROBIN_EN, last_owner=IR.
- All outputs are 0 in reset and in IDLE, except the upstream addr_ready signals described below.
- IDLE:
  - grant = combinational pick among asserted ir_addr_valid/dr_addr_valid.
  - Fixed priority: dr over ir.
  - The granted channel's x_addr_ready=1 in the same cycle; the other channel's addr_ready=0.
  - On a handshake: addr_q<=granted addr, owner<=granted channel, next state REQ.
  - No valid asserted: stay in IDLE.
- REQ:
  - r_addr_valid=1, r_addr=addr_q.
  - Both upstream addr_ready=0.
  - On r_addr_ready: next state RESP.
  - Otherwise hold; addr_q stays stable while r_addr_valid is high (AXI-style rule, no retraction).
- RESP:
  - owner's x_data_valid=r_data_valid and x_data=r_data.
  - Non-owner's data_valid=0 and data=0.
  - r_data_ready = owner's x_data_ready.
  - On r_data_valid && r_data_ready: next state IDLE.
- Latency: upstream addr handshake at cycle N; r_addr_valid at N+1; with a 1-cycle memory, data is presented to the owner at N+3 at the earliest.
- Throughput: at most one transaction per 3 cycles; no pipelining of a second request.
- Simultaneous ir/dr requests in IDLE: only one is granted; the loser keeps valid high and is served after the winner's RESP completes.
- Owner holds data_ready low in RESP: stay in RESP; r_data must remain stable (memory side holds it).
- A new request arriving during REQ/RESP is not acknowledged (addr_ready=0) until the FSM returns to IDLE.
- r_data_valid while not in RESP: ignored, r_data_ready=0. Under `ifdef SIM this is flagged with $display as a protocol error.
- Reset mid-operation: the FSM returns to IDLE and the transaction is dropped. Memory is reset by the same rst, so no stale beat returns.

Optional Feature:
- Macro: READ_ARB_ROUND_ROBIN_EN.
- Defined:
  - last_owner<=owner on each upstream addr handshake.
  - On a simultaneous request, grant goes to the channel that is not last_owner.
  - A single request is granted immediately regardless of last_owner.
- Undefined: fixed dr-over-ir priority; no last_owner register.

Decomposition:
- Shared header (copperv_h.v): BUS_WIDTH, plus new `define constants for the arbiter states (ARB_IDLE, ARB_REQ, ARB_RESP, 2 bits) and owner encoding (ARB_OWNER_IR=0, ARB_OWNER_DR=1).
- One sub-module: read_arb_grant.
  - Purely combinational priority/round-robin picker.
  - Inputs: ir_valid, dr_valid, last_owner.
  - Outputs: gnt_ir, gnt_dr (one-hot or zero).
  - Kept separate so it can be unit-checked exhaustively.

Test Plan:
- ir only, ir_addr=0x10, memory returns 0xDEADBEEF after 1 cycle -> ir_addr_ready=1 at N, r_addr=0x10 at N+1, ir_data=0xDEADBEEF with ir_data_valid, dr_data_valid stays 0.
- ir and dr valid in the same cycle (ir=0x20, dr=0x100), fixed priority -> dr served first (r_addr=0x100), then ir (r_addr=0x20). With READ_ARB_ROUND_ROBIN_EN and last_owner=DR -> ir first.
- Memory deasserts r_addr_ready for 3 cycles in REQ -> r_addr_valid held at 1, r_addr stable at 0x40, no upstream addr_ready during those cycles.
- Owner holds data_ready=0 for 2 cycles in RESP -> data_valid stays 1, data stable, FSM remains in RESP, no new grant.
- rst=0 asserted in RESP -> next cycle: state IDLE, all r_* and data outputs 0. A fresh ir request at 0x0 then completes normally.
- Back-to-back stream of 8 ir reads at 0x0..0x1C with dr idle -> 8 correct beats returned, one transaction per 3 cycles, no dropped or duplicated beats.

Source files
------------

// File: rtl/read_bus_arbiter_pkg.sv
// Shared types for the read-bus arbiter: FSM state and transaction owner encodings.
package read_bus_arbiter_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_IR = 1'b0,
    ARB_OWNER_DR = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/read_arb_grant.sv
// Combinational picker between instruction and data read requests; dr wins ties unless
// READ_ARB_ROUND_ROBIN_EN is defined, in which case ties go to the channel not served last.
module read_arb_grant
  import read_bus_arbiter_pkg::*;
(
  input  logic       ir_valid,
  input  logic       dr_valid,
  input  arb_owner_t last_owner,
  output logic       gnt_ir,
  output logic       gnt_dr
);

`ifndef READ_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  always_comb begin
    gnt_ir = 1'b0;
    gnt_dr = 1'b0;
    if (ir_valid && dr_valid) begin
`ifdef READ_ARB_ROUND_ROBIN_EN
      if (last_owner == ARB_OWNER_DR) gnt_ir = 1'b1;
      else                            gnt_dr = 1'b1;
`else
      gnt_dr = 1'b1;
`endif
    end else begin
      gnt_ir = ir_valid;
      gnt_dr = dr_valid;
    end
  end

endmodule

// File: rtl/read_bus_arbiter.sv
// Single-outstanding arbiter of the ir_* and dr_* read channels onto one memory read port.
// Optional READ_ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests.
module read_bus_arbiter
  import read_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_addr_valid,
  output logic                  ir_addr_ready,
  input  logic [DATA_WIDTH-1:0] ir_addr,
  output logic                  ir_data_valid,
  input  logic                  ir_data_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  input  logic                  dr_addr_valid,
  output logic                  dr_addr_ready,
  input  logic [DATA_WIDTH-1:0] dr_addr,
  output logic                  dr_data_valid,
  input  logic                  dr_data_ready,
  output logic [DATA_WIDTH-1:0] dr_data,
  output logic                  r_addr_valid,
  input  logic                  r_addr_ready,
  output logic [DATA_WIDTH-1:0] r_addr,
  input  logic                  r_data_valid,
  output logic                  r_data_ready,
  input  logic [DATA_WIDTH-1:0] r_data
);

  arb_state_t            state;
  arb_owner_t            owner;
  arb_owner_t            last_owner;
  logic [DATA_WIDTH-1:0] addr_q;
  logic                  gnt_ir, gnt_dr;
  logic                  in_idle, in_req, in_resp;
  logic                  own_ir, own_dr;

`ifdef READ_ARB_ROUND_ROBIN_EN
  arb_owner_t last_owner_q;
  assign last_owner = last_owner_q;
`else
  assign last_owner = ARB_OWNER_IR;
`endif

  read_arb_grant u_grant (
    .ir_valid   (ir_addr_valid),
    .dr_valid   (dr_addr_valid),
    .last_owner (last_owner),
    .gnt_ir     (gnt_ir),
    .gnt_dr     (gnt_dr)
  );

  // Every output is forced to zero while reset is held low.
  assign in_idle = rst && (state == ARB_IDLE);
  assign in_req  = rst && (state == ARB_REQ);
  assign in_resp = rst && (state == ARB_RESP);
  assign own_ir  = in_resp && (owner == ARB_OWNER_IR);
  assign own_dr  = in_resp && (owner == ARB_OWNER_DR);

  always_comb begin
    ir_addr_ready = in_idle && gnt_ir;
    dr_addr_ready = in_idle && gnt_dr;
    r_addr_valid  = in_req;
    r_addr        = in_req ? addr_q : '0;
    ir_data_valid = own_ir && r_data_valid;
    ir_data       = own_ir ? r_data : '0;
    dr_data_valid = own_dr && r_data_valid;
    dr_data       = own_dr ? r_data : '0;
    r_data_ready  = (own_ir && ir_data_ready) || (own_dr && dr_data_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ARB_IDLE;
      owner  <= ARB_OWNER_IR;
      addr_q <= '0;
`ifdef READ_ARB_ROUND_ROBIN_EN
      last_owner_q <= ARB_OWNER_IR;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_dr) begin
            addr_q <= dr_addr;
            owner  <= ARB_OWNER_DR;
            state  <= ARB_REQ;
`ifdef READ_ARB_ROUND_ROBIN_EN
            last_owner_q <= ARB_OWNER_DR;
`endif
          end else if (gnt_ir) begin
            addr_q <= ir_addr;
            owner  <= ARB_OWNER_IR;
            state  <= ARB_REQ;
`ifdef READ_ARB_ROUND_ROBIN_EN
            last_owner_q <= ARB_OWNER_IR;
`endif
          end
        end
        ARB_REQ: begin
          if (r_addr_ready) state <= ARB_RESP;
        end
        ARB_RESP: begin
          if (r_data_valid && r_data_ready) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef SIM
  always_ff @(posedge clk) begin
    if (rst && r_data_valid && (state != ARB_RESP))
      $display("read_bus_arbiter: protocol error, r_data_valid outside RESP");
  end
`endif

endmodule

// File: tb/tb_read_bus_arbiter.sv
// Directed self-checking bench for read_bus_arbiter; memory side is driven by hand per scenario.
module tb_read_bus_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ir_addr_valid = 1'b0, ir_addr_ready, ir_data_valid, ir_data_ready = 1'b1;
  logic [W-1:0] ir_addr = '0, ir_data;
  logic         dr_addr_valid = 1'b0, dr_addr_ready, dr_data_valid, dr_data_ready = 1'b1;
  logic [W-1:0] dr_addr = '0, dr_data;
  logic         r_addr_valid, r_addr_ready = 1'b0, r_data_valid = 1'b0, r_data_ready;
  logic [W-1:0] r_addr, r_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] a_seen, ir_d, dr_d;
  logic         ir_v, dr_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  read_bus_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .r_addr_valid(r_addr_valid), .r_addr_ready(r_addr_ready), .r_addr(r_addr),
    .r_data_valid(r_data_valid), .r_data_ready(r_data_ready), .r_data(r_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Called just after the grant edge: accepts the request, waits lat cycles, returns one beat.
  task automatic serve(input logic [W-1:0] data, input int lat,
                       output logic [W-1:0] addr_seen,
                       output logic iv, output logic [W-1:0] id,
                       output logic dv, output logic [W-1:0] dd);
    r_addr_ready = 1'b1;
    settle;
    addr_seen = r_addr_valid ? r_addr : 'x;
    tick;
    r_addr_ready = 1'b0;
    for (int k = 0; k < lat; k++) begin
      r_data_valid = 1'b0;
      settle;
      tick;
    end
    r_data_valid = 1'b1;
    r_data = data;
    settle;
    iv = ir_data_valid; id = ir_data; dv = dr_data_valid; dd = dr_data;
    tick;
    r_data_valid = 1'b0;
    r_data = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ir_addr_valid = 1'b1; dr_addr_valid = 1'b1; r_data_valid = 1'b1;
    tick; tick;
    settle;
    checks++;
    if (r_addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_addr_valid got %b want 0", r_addr_valid); end
    checks++;
    if (r_data_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_data_ready got %b want 0", r_data_ready); end
    checks++;
    if ({ir_data_valid, dr_data_valid} !== 2'b00) begin errors++; $display("[TB] FAIL reset_data_valid got %b want 00", {ir_data_valid, dr_data_valid}); end
    ir_addr_valid = 1'b0; dr_addr_valid = 1'b0; r_data_valid = 1'b0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_ir_single;
    ir_addr_valid = 1'b1; ir_addr = 32'h10;
    settle;
    checks++;
    if ({ir_addr_ready, dr_addr_ready, r_addr_valid} !== 3'b100) begin errors++; $display("[TB] FAIL single_grant got %b want 100", {ir_addr_ready, dr_addr_ready, r_addr_valid}); end
    tick;
    ir_addr_valid = 1'b0;
    serve(32'hDEADBEEF, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h10) begin errors++; $display("[TB] FAIL single_r_addr got %h want 00000010", a_seen); end
    checks++;
    if (ir_v !== 1'b1 || ir_d !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_ir_data got %b/%h want 1/deadbeef", ir_v, ir_d); end
    checks++;
    if (dr_v !== 1'b0) begin errors++; $display("[TB] FAIL single_dr_quiet got %b want 0", dr_v); end
  endtask

  task automatic test_priority;
    ir_addr_valid = 1'b1; ir_addr = 32'h20;
    dr_addr_valid = 1'b1; dr_addr = 32'h100;
    settle;
    checks++;
    if ({dr_addr_ready, ir_addr_ready} !== 2'b10) begin errors++; $display("[TB] FAIL prio_grant got %b want 10", {dr_addr_ready, ir_addr_ready}); end
    tick;
    dr_addr_valid = 1'b0;
    serve(32'h11111111, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h100 || dr_v !== 1'b1 || dr_d !== 32'h11111111 || ir_v !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_first got addr %h dr %b/%h ir %b want 100 1/11111111 0", a_seen, dr_v, dr_d, ir_v);
    end
    settle;
    checks++;
    if (ir_addr_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_loser_grant got %b want 1", ir_addr_ready); end
    tick;
    ir_addr_valid = 1'b0;
    serve(32'h22222222, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h20 || ir_v !== 1'b1 || ir_d !== 32'h22222222 || dr_v !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_second got addr %h ir %b/%h dr %b want 20 1/22222222 0", a_seen, ir_v, ir_d, dr_v);
    end
  endtask

  task automatic test_req_stall;
    ir_addr_valid = 1'b1; ir_addr = 32'h40;
    tick;
    ir_addr_valid = 1'b0;
    dr_addr_valid = 1'b1; dr_addr = 32'h80;
    r_addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++;
      if (r_addr_valid !== 1'b1 || r_addr !== 32'h40 || ir_addr_ready !== 1'b0 || dr_addr_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b a=%h rdy=%b%b want 1 40 00", i, r_addr_valid, r_addr, ir_addr_ready, dr_addr_ready);
      end
      tick;
    end
    serve(32'h40404040, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h40 || ir_v !== 1'b1 || ir_d !== 32'h40404040) begin
      errors++; $display("[TB] FAIL stall_beat got %h %b/%h want 40 1/40404040", a_seen, ir_v, ir_d);
    end
    settle;
    checks++;
    if (dr_addr_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_pending_dr got %b want 1", dr_addr_ready); end
    tick;
    dr_addr_valid = 1'b0;
    serve(32'h80808080, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h80 || dr_v !== 1'b1 || dr_d !== 32'h80808080) begin
      errors++; $display("[TB] FAIL stall_dr_beat got %h %b/%h want 80 1/80808080", a_seen, dr_v, dr_d);
    end
  endtask

  task automatic test_resp_hold;
    ir_addr_valid = 1'b1; ir_addr = 32'h44;
    tick;
    ir_addr_valid = 1'b0;
    r_addr_ready = 1'b1;
    tick;
    r_addr_ready = 1'b0;
    ir_data_ready = 1'b0;
    r_data_valid = 1'b1; r_data = 32'hCAFEF00D;
    dr_addr_valid = 1'b1; dr_addr = 32'h84;
    for (int i = 0; i < 2; i++) begin
      settle;
      checks++;
      if (ir_data_valid !== 1'b1 || ir_data !== 32'hCAFEF00D || r_data_ready !== 1'b0 || dr_addr_ready !== 1'b0 || r_addr_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL hold[%0d] got v=%b d=%h rr=%b dar=%b rav=%b want 1 cafef00d 0 0 0", i, ir_data_valid, ir_data, r_data_ready, dr_addr_ready, r_addr_valid);
      end
      tick;
    end
    ir_data_ready = 1'b1;
    settle;
    checks++;
    if (r_data_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release got %b want 1", r_data_ready); end
    tick;
    r_data_valid = 1'b0; r_data = '0;
    settle;
    checks++;
    if (dr_addr_ready !== 1'b1 || ir_data_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_back_idle got dar=%b idv=%b want 1 0", dr_addr_ready, ir_data_valid);
    end
    dr_addr_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_in_resp;
    ir_addr_valid = 1'b1; ir_addr = 32'h48;
    tick;
    ir_addr_valid = 1'b0;
    r_addr_ready = 1'b1;
    tick;
    r_addr_ready = 1'b0;
    r_data_valid = 1'b1; r_data = 32'h12345678;
    ir_data_ready = 1'b0;
    settle;
    checks++;
    if (ir_data_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstresp_pre got %b want 1", ir_data_valid); end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    ir_data_ready = 1'b1;
    settle;
    checks++;
    if (r_addr_valid !== 1'b0 || r_addr !== '0 || r_data_ready !== 1'b0 || ir_data_valid !== 1'b0 || ir_data !== '0) begin
      errors++; $display("[TB] FAIL rstresp_idle got rav=%b ra=%h rdr=%b idv=%b id=%h want all 0", r_addr_valid, r_addr, r_data_ready, ir_data_valid, ir_data);
    end
    r_data_valid = 1'b0; r_data = '0;
    ir_addr_valid = 1'b1; ir_addr = 32'h0;
    settle;
    checks++;
    if (ir_addr_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstresp_regrant got %b want 1", ir_addr_ready); end
    tick;
    ir_addr_valid = 1'b0;
    serve(32'h0BADF00D, 1, a_seen, ir_v, ir_d, dr_v, dr_d);
    checks++;
    if (a_seen !== 32'h0 || ir_v !== 1'b1 || ir_d !== 32'h0BADF00D) begin
      errors++; $display("[TB] FAIL rstresp_fresh got %h %b/%h want 0 1/0badf00d", a_seen, ir_v, ir_d);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    int beats;
    logic [W-1:0] a;
    beats = 0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i * 4);
      ir_addr_valid = 1'b1; ir_addr = a;
      settle;
      checks++;
      if (ir_addr_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_grant[%0d] got %b want 1", i, ir_addr_ready); end
      tick;
      serve(32'hB0000000 | a, 0, a_seen, ir_v, ir_d, dr_v, dr_d);
      if (ir_v === 1'b1) beats++;
      checks++;
      if (a_seen !== a || ir_d !== (32'hB0000000 | a) || dr_v !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_beat[%0d] got addr %h data %h dr %b want %h %h 0", i, a_seen, ir_d, dr_v, a, 32'hB0000000 | a);
      end
    end
    ir_addr_valid = 1'b0;
    checks++;
    if (beats !== 8) begin errors++; $display("[TB] FAIL b2b_count got %0d want 8", beats); end
    checks++;
    if (cyc - c0 !== 24) begin errors++; $display("[TB] FAIL b2b_cycles got %0d want 24", cyc - c0); end
  endtask

  initial begin
    test_reset;
    test_ir_single;
    test_priority;
    test_req_stall;
    test_resp_hold;
    test_reset_in_resp;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
